// File: rtl/stream_hash_pkg.sv
// Shared types and helpers for the multi-context stream hash core:
// the management opcode set, the per-word mixing step and channel decode.
package stream_hash_pkg;

   typedef enum logic [1:0] {
      OP_INIT      = 2'b00,
      OP_READ      = 2'b01,
      OP_READ_INIT = 2'b10,
      OP_RSVD      = 2'b11
   } op_e;

   // Width-generic mixing step on a w-bit state carried in 64 bits.
   function automatic logic [63:0] hash_step(input logic [63:0] h,
                                             input logic [63:0] x,
                                             input int          rot,
                                             input logic [63:0] k,
                                             input int          w);
      logic [63:0] mask;
      logic [63:0] v;
      logic [63:0] r;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      v    = (h ^ x) & mask;
      r    = ((v << rot) | (v >> (w - rot))) & mask;
      return (r + k) & mask;
   endfunction

   function automatic logic is_mgmt(input int ch, input int num_ctx);
      return (ch >= num_ctx);
   endfunction

   function automatic int ctx_idx(input int ch, input int num_ctx);
      return (ch >= num_ctx) ? (ch - num_ctx) : ch;
   endfunction

endpackage

// File: rtl/stream_hash_out_reg.sv
// One-entry result register for the Avalon-ST source; load appears on the next edge.
// Sink ready is held low through reset and the first edge after it, then follows !valid || out_ready.
module stream_hash_out_reg #(
   parameter int HASH_W = 32,
   parameter int CH_W   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic [HASH_W-1:0] i_dat,
   input  logic [CH_W-1:0]   i_ch,
   input  logic              i_out_ready,
   output logic              o_in_ready,
   output logic              o_vld,
   output logic [HASH_W-1:0] o_dat,
   output logic [CH_W-1:0]   o_ch
);

   logic              r_en;
   logic              r_vld;
   logic [HASH_W-1:0] r_dat;
   logic [CH_W-1:0]   r_ch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en  <= 1'b0;
         r_vld <= 1'b0;
         r_dat <= '0;
         r_ch  <= '0;
      end else begin
         r_en <= 1'b1;
         if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
            r_ch  <= i_ch;
         end else if (i_out_ready) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign o_in_ready = r_en && (!r_vld || i_out_ready);
   assign o_vld      = r_vld;
   assign o_dat      = r_dat;
   assign o_ch       = r_ch;

endmodule

// File: rtl/stream_hash_multi.sv
// Multi-context streaming hash: data beats mix into context c, management beats init/read it.
// READ result is valid one edge after acceptance; all channels stall together while a result is unclaimed.
module stream_hash_multi
   import stream_hash_pkg::*;
#(
   parameter int          DATA_W    = 16,
   parameter int          HASH_W    = 32,
   parameter int          NUM_CTX   = 2,
   parameter int          ROT       = 5,
   parameter logic [31:0] MIX_CONST = 32'h9E3779B9,
   parameter logic [31:0] SEED      = 32'h0,
   parameter int          CH_W      = $clog2(2*NUM_CTX)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CH_W-1:0]   in_channel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [HASH_W-1:0] out_data,
   output logic [CH_W-1:0]   out_channel,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int                IDX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
   localparam logic [HASH_W-1:0] K_H    = HASH_W'(MIX_CONST);
   localparam logic [HASH_W-1:0] SEED_H = HASH_W'(SEED);

   logic [HASH_W-1:0] r_ctx [NUM_CTX];

   logic              w_acc;
   logic              w_ch_ok;
   logic              w_mgmt;
   logic [IDX_W-1:0]  w_idx;
   logic [HASH_W-1:0] w_x;
   logic [HASH_W-1:0] w_cur;
   logic [HASH_W-1:0] w_next;
   op_e               w_op;
   logic              w_load;
   logic              w_clear;

   assign w_acc   = in_valid && in_ready;
   // Unmapped channels are consumed but never touch a context or the output.
   assign w_ch_ok = int'(in_channel) < 2*NUM_CTX;
   assign w_mgmt  = is_mgmt(int'(in_channel), NUM_CTX);
   assign w_idx   = IDX_W'(ctx_idx(int'(in_channel), NUM_CTX));
   assign w_x     = HASH_W'(in_data);
   assign w_op    = op_e'(w_x[1:0]);
   assign w_cur   = r_ctx[w_idx];
   assign w_next  = HASH_W'(hash_step(64'(w_cur), 64'(w_x), ROT, 64'(K_H), HASH_W));

   assign w_load  = w_acc && w_ch_ok && w_mgmt && (w_op == OP_READ || w_op == OP_READ_INIT);
   assign w_clear = w_acc && w_ch_ok && w_mgmt && (w_op == OP_INIT || w_op == OP_READ_INIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CTX; i++) r_ctx[i] <= SEED_H;
      end else if (w_acc && w_ch_ok && !w_mgmt) begin
         r_ctx[w_idx] <= w_next;
      end else if (w_clear) begin
         r_ctx[w_idx] <= SEED_H;
      end
   end

   stream_hash_out_reg #(
      .HASH_W (HASH_W),
      .CH_W   (CH_W)
   ) u_out_reg (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_load      (w_load),
      .i_dat       (w_cur),
      .i_ch        (CH_W'(w_idx)),
      .i_out_ready (out_ready),
      .o_in_ready  (in_ready),
      .o_vld       (out_valid),
      .o_dat       (out_data),
      .o_ch        (out_channel)
   );

endmodule

// File: tb/tb_stream_hash_multi.sv
// Directed bench for stream_hash_multi at default parameters: vector table plus
// hand-written reset, backpressure and mid-stream reset sequences.
module tb_stream_hash_multi;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] in_data;
   logic [1:0]  in_channel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [1:0]  out_channel;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] dat;
      logic        exp_vld;
      logic [31:0] exp_dat;
      logic [1:0]  exp_ch;
   } vec_t;

   vec_t vecs [20];

   stream_hash_multi dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_data     (in_data),
      .in_channel  (in_channel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_channel (out_channel),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one beat, wait (bounded) until accepted, return #1 after the accept edge.
   task automatic beat(input logic [1:0] ch, input logic [15:0] dat);
      int n;
      in_valid   = 1'b1;
      in_channel = ch;
      in_data    = dat;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 'x;
   endtask

   initial begin
      vecs[0]  = '{2'd2, 16'h0000, 1'b0, 32'h0,        2'd0};
      vecs[1]  = '{2'd0, 16'h4949, 1'b0, 32'h0,        2'd0};
      vecs[2]  = '{2'd2, 16'h0001, 1'b1, 32'h9E40A2D9, 2'd0};
      vecs[3]  = '{2'd2, 16'h0000, 1'b0, 32'h0,        2'd0};
      vecs[4]  = '{2'd0, 16'h4949, 1'b0, 32'h0,        2'd0};
      vecs[5]  = '{2'd0, 16'hB5DE, 1'b0, 32'h0,        2'd0};
      vecs[6]  = '{2'd2, 16'h0001, 1'b1, 32'h663A5AAC, 2'd0};
      vecs[7]  = '{2'd2, 16'h0000, 1'b0, 32'h0,        2'd0};
      vecs[8]  = '{2'd3, 16'h0000, 1'b0, 32'h0,        2'd0};
      vecs[9]  = '{2'd0, 16'h4949, 1'b0, 32'h0,        2'd0};
      vecs[10] = '{2'd1, 16'h4949, 1'b0, 32'h0,        2'd0};
      vecs[11] = '{2'd0, 16'hB5DE, 1'b0, 32'h0,        2'd0};
      vecs[12] = '{2'd2, 16'h0001, 1'b1, 32'h663A5AAC, 2'd0};
      vecs[13] = '{2'd3, 16'h0001, 1'b1, 32'h9E40A2D9, 2'd1};
      vecs[14] = '{2'd2, 16'h0000, 1'b0, 32'h0,        2'd0};
      vecs[15] = '{2'd0, 16'h4949, 1'b0, 32'h0,        2'd0};
      vecs[16] = '{2'd2, 16'h0002, 1'b1, 32'h9E40A2D9, 2'd0};
      vecs[17] = '{2'd2, 16'h0001, 1'b1, 32'h0,        2'd0};
      vecs[18] = '{2'd3, 16'h0003, 1'b0, 32'h0,        2'd0};
      vecs[19] = '{2'd3, 16'h0001, 1'b1, 32'h9E40A2D9, 2'd1};

      reset_n    = 1'b0;
      in_valid   = 1'b0;
      in_data    = 'x;
      in_channel = '0;
      out_ready  = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_channel", 32'(out_channel), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("release_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("release_in_ready_high", 32'(in_ready), 32'd1);

      for (int i = 0; i < 20; i++) begin
         beat(vecs[i].ch, vecs[i].dat);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
         if (vecs[i].exp_vld) begin
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_dat);
            chk($sformatf("vec%0d_chan", i), 32'(out_channel), 32'(vecs[i].exp_ch));
         end
      end

      // Backpressure: first result must hold, second READ must wait.
      beat(2'd2, 16'h0000);
      beat(2'd0, 16'h4949);
      beat(2'd0, 16'hB5DE);
      out_ready = 1'b0;
      beat(2'd2, 16'h0001);
      chk("bp_first_valid", 32'(out_valid), 32'd1);
      in_valid   = 1'b1;
      in_channel = 2'd3;
      in_data    = 16'h0001;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_data", i), out_data, 32'h663A5AAC);
         chk($sformatf("bp%0d_chan", i), 32'(out_channel), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_second_valid", 32'(out_valid), 32'd1);
      chk("bp_second_data", out_data, 32'h9E40A2D9);
      chk("bp_second_chan", 32'(out_channel), 32'd1);
      @(posedge clk);
      #1;
      chk("bp_no_dup", 32'(out_valid), 32'd0);

      // Mid-stream reset with a pending result.
      beat(2'd0, 16'h4949);
      out_ready = 1'b0;
      beat(2'd2, 16'h0001);
      chk("mr_pending_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mr_async_valid", 32'(out_valid), 32'd0);
      chk("mr_async_data", out_data, 32'h0);
      chk("mr_async_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      beat(2'd2, 16'h0001);
      chk("mr_ctx0_valid", 32'(out_valid), 32'd1);
      chk("mr_ctx0_data", out_data, 32'h0);
      beat(2'd3, 16'h0001);
      chk("mr_ctx1_data", out_data, 32'h0);
      chk("mr_ctx1_chan", 32'(out_channel), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
